bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the system bus among four bus masters.
- Masters request ownership with active-low request lines and receive one active-low grant; exactly one grant is asserted at all times (bus parking).
- The granted master drives the bus address that the slave-select decoder consumes.
- A configurable hold limit forces a handover when one master monopolises the bus while others wait.

---
 rtl/bus_arbiter_if.sv | 24 ++
 rtl/bus_arbiter.sv | 97 +++++++++
 tb/tb_bus_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the four bus masters and the round-robin arbiter.
// The masters drive the requests; the arbiter drives the grants, owner and preempt.
interface bus_arbiter_if;
  logic       m0_req_;
  logic       m1_req_;
  logic       m2_req_;
  logic       m3_req_;
  logic       m0_grnt_;
  logic       m1_grnt_;
  logic       m2_grnt_;
  logic       m3_grnt_;
  logic [1:0] owner;
  logic       preempt;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, preempt
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, preempt
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with a parked, active-low one-hot grant
// and an optional hold limit that forces handover under contention.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_M0 = 2'd0,
    OWN_M1 = 2'd1,
    OWN_M2 = 2'd2,
    OWN_M3 = 2'd3
  } owner_t;

  typedef enum logic {
    ENABLE_  = 1'b0,
    DISABLE_ = 1'b1
  } grnt_t;

  // Hold counter ceiling; with MAX_HOLD == 0 it simply saturates at all-ones.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);

  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;
  logic [3:0]       grnt_q, grnt_d;

  logic [3:0]       req_n;
  logic             have_next;
  owner_t           next_own;

  assign req_n = {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

  // Scan owner+1 .. owner+3; the current owner is never its own successor.
  always_comb begin
    logic [1:0] cand;
    have_next = 1'b0;
    next_own  = owner_q;
    cand      = owner_q;
    for (int unsigned k = 1; k < 4; k++) begin
      cand = owner_q + 2'(k);
      if (!have_next && !req_n[cand]) begin
        have_next = 1'b1;
        next_own  = owner_t'(cand);
      end
    end
  end

  always_comb begin
    owner_d   = owner_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    grnt_d    = '1;

    if (req_n[owner_q]) begin
      hold_d = '0;
      if (have_next) owner_d = next_own;
    end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && have_next) begin
      owner_d   = next_own;
      hold_d    = '0;
      preempt_d = 1'b1;
    end else if (hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end

    // Grants are decoded from the next owner so they register alongside it.
    for (int unsigned i = 0; i < 4; i++) begin
      grnt_d[i] = (owner_d == owner_t'(2'(i))) ? ENABLE_ : DISABLE_;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= OWN_M0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
      grnt_q    <= {DISABLE_, DISABLE_, DISABLE_, ENABLE_};
    end else begin
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
      grnt_q    <= grnt_d;
    end
  end

  assign bus.m0_grnt_ = grnt_q[0];
  assign bus.m1_grnt_ = grnt_q[1];
  assign bus.m2_grnt_ = grnt_q[2];
  assign bus.m3_grnt_ = grnt_q[3];
  assign bus.owner    = owner_q;
  assign bus.preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: two instances (hold limit 4 and disabled)
// checked against a behavioural round-robin model, plus directed scenarios.
module tb_bus_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if ifa ();
  bus_arbiter_if ifb ();

  bus_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  bus_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct {
    int own;
    bit pre;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   m_own[2];
  int   m_hold[2];
  int   maxh[2] = '{4, 0};

  int   vectors     = 0;
  int   miscompares = 0;

  int   waits[4];
  int   max_wait = 0;
  bit   rec = 1'b0;
  int   seen[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] grants_a();
    return {ifa.m3_grnt_, ifa.m2_grnt_, ifa.m1_grnt_, ifa.m0_grnt_};
  endfunction

  function automatic logic [3:0] grants_b();
    return {ifb.m3_grnt_, ifb.m2_grnt_, ifb.m1_grnt_, ifb.m0_grnt_};
  endfunction

  // Reference: round-robin from the owner, release/park/preempt/hold rules.
  function automatic exp_t model_step(input int d, input logic [3:0] req_n);
    exp_t e;
    int   nxt;
    int   lim;
    bit   want[4];
    for (int i = 0; i < 4; i++) want[i] = (req_n[i] == 1'b0);
    nxt = -1;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_own[d] + k) % 4;
      if (nxt < 0 && want[c]) nxt = c;
    end
    lim   = (maxh[d] == 0) ? 255 : maxh[d] - 1;
    e.pre = 1'b0;
    if (!want[m_own[d]]) begin
      if (nxt >= 0) m_own[d] = nxt;
      m_hold[d] = 0;
    end else if (maxh[d] > 0 && m_hold[d] == maxh[d] - 1 && nxt >= 0) begin
      m_own[d]  = nxt;
      m_hold[d] = 0;
      e.pre     = 1'b1;
    end else if (m_hold[d] < lim) begin
      m_hold[d]++;
    end
    e.own = m_own[d];
    return e;
  endfunction

  task automatic step(input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    {ifa.m3_req_, ifa.m2_req_, ifa.m1_req_, ifa.m0_req_} = ra;
    {ifb.m3_req_, ifb.m2_req_, ifb.m1_req_, ifb.m0_req_} = rb;
    qa.push_back(model_step(0, ra));
    qb.push_back(model_step(1, rb));
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_grants_a", int'(grants_a()), 4'b1110);
    chk("rst_owner_a", int'(ifa.owner), 0);
    chk("rst_preempt_a", int'(ifa.preempt), 0);
    chk("rst_grants_b", int'(grants_b()), 4'b1110);
    qa.delete();
    qb.delete();
    m_own  = '{0, 0};
    m_hold = '{0, 0};
    for (int i = 0; i < 4; i++) waits[i] = 0;
    {ifa.m3_req_, ifa.m2_req_, ifa.m1_req_, ifa.m0_req_} = 4'hF;
    {ifb.m3_req_, ifb.m2_req_, ifb.m1_req_, ifb.m0_req_} = 4'hF;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops one expectation per edge for each instance and compares.
  exp_t ea, eb;
  logic [3:0] mon_req;
  always @(posedge clk) begin
    #1;
    if (!reset && qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_owner", int'(ifa.owner), ea.own);
      chk("a_grants", int'(grants_a()), int'(4'hF ^ (4'b0001 << ea.own)));
      chk("a_preempt", int'(ifa.preempt), int'(ea.pre));
      mon_req = {ifa.m3_req_, ifa.m2_req_, ifa.m1_req_, ifa.m0_req_};
      for (int i = 0; i < 4; i++) begin
        if (mon_req[i] == 1'b0 && int'(ifa.owner) != i) waits[i]++;
        else waits[i] = 0;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
      if (rec && seen.size() > 0 && int'(ifa.owner) != seen[$]) seen.push_back(int'(ifa.owner));
    end
    if (!reset && qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_owner", int'(ifb.owner), eb.own);
      chk("b_grants", int'(grants_b()), int'(4'hF ^ (4'b0001 << eb.own)));
      chk("b_preempt", int'(ifb.preempt), int'(eb.pre));
    end
  end

  initial begin
    int         chg;
    int         own_cnt;
    int         last;
    logic [3:0] r;

    {ifa.m3_req_, ifa.m2_req_, ifa.m1_req_, ifa.m0_req_} = 4'hF;
    {ifb.m3_req_, ifb.m2_req_, ifb.m1_req_, ifb.m0_req_} = 4'hF;
    #3;
    do_reset();

    // Idle bus, m2 requests, then releases and the grant stays parked.
    step(4'b1011, 4'hF);
    chk("m2_owner", int'(ifa.owner), 2);
    chk("m2_grnt", int'(ifa.m2_grnt_), 0);
    for (int i = 0; i < 3; i++) step(4'hF, 4'hF);
    chk("park_owner", int'(ifa.owner), 2);

    // Owner 1 releasing with m0 and m3 requesting: scan reaches m3 first.
    do_reset();
    step(4'b1101, 4'hF);
    chk("own1", int'(ifa.owner), 1);
    step(4'b0110, 4'hF);
    chk("scan_m3", int'(ifa.owner), 3);
    step(4'b1110, 4'hF);
    chk("then_m0", int'(ifa.owner), 0);

    // Asynchronous reset while m2 holds the bus.
    do_reset();
    step(4'b1011, 4'hF);
    step(4'b1011, 4'hF);
    chk("hold_owner2", int'(ifa.owner), 2);
    do_reset();

    // Contended holder: limit 4 forces a handover, limit 0 never does.
    chg = 0;
    for (int s = 1; s <= 300; s++) begin
      step(4'b1100, 4'b1100);
      if (chg != 0 && s == chg + 1) chk("preempt_clears", int'(ifa.preempt), 0);
      if (chg == 0 && ifa.owner != 2'd0) begin
        chg = s;
        chk("preempt_pulse", int'(ifa.preempt), 1);
        chk("preempt_m1_grnt", int'(ifa.m1_grnt_), 0);
      end
    end
    chk("preempt_edge", chg, 4);
    chk("nolimit_owner", int'(ifb.owner), 0);

    // Everyone requesting, owner drops req_ after 3 granted cycles.
    do_reset();
    seen.delete();
    seen.push_back(0);
    rec     = 1'b1;
    own_cnt = 0;
    last    = 0;
    for (int c = 0; c < 40 && seen.size() < 5; c++) begin
      r = 4'b0000;
      if (m_own[0] == last) own_cnt++;
      else begin
        last    = m_own[0];
        own_cnt = 1;
      end
      if (own_cnt >= 3) r[last] = 1'b1;
      step(r, 4'hF);
    end
    rec = 1'b0;
    chk("rr_seq_len", seen.size(), 5);
    for (int i = 0; i < seen.size() && i < 5; i++) chk($sformatf("rr_seq[%0d]", i), seen[i], i % 4);

    // Randomised request traffic on both instances.
    do_reset();
    max_wait = 0;
    r = 4'hF;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      step(r, r);
    end
    vectors++;
    if (max_wait > 15) begin
      miscompares++;
      $display("FAIL max_wait: got %0d cycles, limit 15", max_wait);
    end

    step(4'hF, 4'hF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
